// File: rtl/uart_tx_core.sv
// UART transmitter core: start bit, LSB-first data, optional parity, one or two
// stop bits, with a PRESCALE clock-per-bit rate and back-to-back frame support.
module uart_tx_core #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_type,
  input  logic                  stop2,
  output logic                  tx_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int BW = $clog2(DATA_WIDTH);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_n;
  logic [PW-1:0]         pcnt, pcnt_n;
  logic [BW-1:0]         bcnt, bcnt_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;
  logic                  par_bit_q, par_bit_n;
  logic                  par_en_q, par_en_n;
  logic                  stop2_q, stop2_n;
  logic                  tx_n, busy_n, fd_n;
  logic                  bit_end, accept;

  assign bit_end = (pcnt == PW'(PRESCALE - 1));

  // Outputs are computed from the next state and registered, so tx_out changes
  // exactly on bit boundaries and shows the start bit the cycle after acceptance.
  always_comb begin
    state_n   = state;
    pcnt_n    = bit_end ? '0 : pcnt + PW'(1);
    bcnt_n    = bcnt;
    sh_n      = sh;
    par_bit_n = par_bit_q;
    par_en_n  = par_en_q;
    stop2_n   = stop2_q;
    tx_n      = tx_out;
    busy_n    = busy;
    fd_n      = 1'b0;
    accept    = 1'b0;

    unique case (state)
      IDLE: begin
        pcnt_n = '0;
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (data_valid) accept = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_n = DATA;
          bcnt_n  = '0;
          tx_n    = sh[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bcnt == BW'(DATA_WIDTH - 1)) begin
            bcnt_n = '0;
            if (par_en_q) begin
              state_n = PARITY;
              tx_n    = par_bit_q;
            end else begin
              state_n = STOP;
              tx_n    = 1'b1;
            end
          end else begin
            bcnt_n = bcnt + BW'(1);
            sh_n   = sh >> 1;
            tx_n   = sh[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_n = STOP;
          bcnt_n  = '0;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (stop2_q && bcnt == '0) begin
            bcnt_n = BW'(1);
          end else begin
            fd_n = 1'b1;
            if (data_valid) begin
              accept = 1'b1;
            end else begin
              state_n = IDLE;
              busy_n  = 1'b0;
              tx_n    = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Parity is resolved at acceptance so the data register can be shifted out.
    if (accept) begin
      state_n   = START;
      sh_n      = p_data;
      par_bit_n = (^p_data) ^ par_type;
      par_en_n  = par_en;
      stop2_n   = stop2;
      bcnt_n    = '0;
      pcnt_n    = '0;
      tx_n      = 1'b0;
      busy_n    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pcnt       <= '0;
      bcnt       <= '0;
      sh         <= '0;
      par_bit_q  <= 1'b0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      pcnt       <= pcnt_n;
      bcnt       <= bcnt_n;
      sh         <= sh_n;
      par_bit_q  <= par_bit_n;
      par_en_q   <= par_en_n;
      stop2_q    <= stop2_n;
      tx_out     <= tx_n;
      busy       <= busy_n;
      frame_done <= fd_n;
    end
  end

endmodule

// File: doc/uart_tx_core.md
UART_TX_CORE -- requirements
Module: uart_tx_core

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-002 SHALL have parameter PRESCALE, default 1, clk cycles per serial bit, legal range >=1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port p_data  input  DATA_WIDTH  parallel data to send.
REQ-006 SHALL have port data_valid  input  1  request to send p_data.
REQ-007 SHALL have port par_en  input  1  1 = append parity bit.
REQ-008 SHALL have port par_type  input  1  0 = even parity, 1 = odd parity.
REQ-009 SHALL have port stop2  input  1  0 = one stop bit, 1 = two stop bits.
REQ-010 SHALL have port tx_out  output  1  registered serial line, idle high.
REQ-011 SHALL have port busy  output  1  registered, high while a frame is in progress.
REQ-012 SHALL have port frame_done  output  1  registered one-cycle pulse at end of each frame.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL accept a frame when data_valid=1 while in IDLE, or on the last clk of the final stop bit (back-to-back); data_valid at any other time SHALL be ignored.
REQ-015 On acceptance SHALL latch p_data, par_en, par_type, stop2 into internal registers; input changes mid-frame SHALL NOT affect the frame.
REQ-016 Each serial bit SHALL last exactly PRESCALE clk cycles, counted by an internal prescale counter reset at every bit boundary.
REQ-017 Frame order: start bit 0; DATA_WIDTH data bits LSB first; parity bit if par_en; one or two stop bits (1) per stop2.
REQ-018 Parity bit SHALL be XOR of latched data when par_type=0, its inverse when par_type=1.
REQ-019 tx_out SHALL show the first start-bit value in the cycle after the acceptance edge; all line transitions SHALL occur on bit boundaries only.
REQ-020 Transitions: IDLE->START on acceptance; START->DATA after 1 bit; DATA->PARITY (par_en) or STOP (else) after DATA_WIDTH bits; PARITY->STOP after 1 bit; STOP->START on back-to-back acceptance, else IDLE, after 1 or 2 bits.
REQ-021 busy SHALL be 1 in every state except IDLE; with back-to-back frames busy SHALL stay 1 continuously.
REQ-022 frame_done SHALL pulse high for exactly one clk, in the first cycle after the final stop bit ends, including between back-to-back frames.
REQ-023 Frame length in clks SHALL be PRESCALE*(2+DATA_WIDTH+par_en+stop2).
REQ-024 Bit counter SHALL be sized to hold DATA_WIDTH-1 without overflow; prescale counter to hold PRESCALE-1.
REQ-025 In IDLE tx_out SHALL be 1; no state other than START/DATA/PARITY SHALL drive 0.

Reset
REQ-026 On reset assertion, immediately and regardless of clk: state=IDLE, tx_out=1, busy=0, frame_done=0, counters and latched data cleared.
REQ-027 Reset mid-frame SHALL abort the frame; no frame_done pulse for the aborted frame.
REQ-028 After reset deassertion, first acceptance SHALL require a fresh data_valid sampled on a rising clk edge.

Verification
REQ-029 DATA_WIDTH=8, PRESCALE=1, par_en=0, stop2=0, p_data=0xA5 -> tx_out 0,1,0,1,0,0,1,0,1,1 over 10 clks; busy high 10 clks; frame_done pulse on clk 11.
REQ-030 Same with par_en=1: par_type=0 -> parity bit 0; par_type=1 -> parity bit 1; frame 11 clks.
REQ-031 PRESCALE=4, stop2=1, p_data=0x01, par_en=0 -> each bit held 4 clks, two stop bits, frame 44 clks, busy high for all 44.
REQ-032 data_valid held high continuously, 0x55 then 0x0F -> second start bit immediately after first stop bit, busy never drops, frame_done pulses once per frame.
REQ-033 p_data and par_type toggled mid-frame -> transmitted bits and parity match values latched at acceptance.
REQ-034 reset asserted during DATA bit 3 -> tx_out=1, busy=0 same cycle; no frame_done; next data_valid starts a clean frame.
